// File: rtl/mem_access_pkg.sv
// Shared encodings and alignment helpers for the memory access unit.
package mem_access_pkg;

  typedef enum logic [1:0] {
    SZ_BYTE = 2'd0,
    SZ_HALF = 2'd1,
    SZ_UNAL = 2'd2,
    SZ_WORD = 2'd3
  } size_e;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    RD0  = 3'd1,
    RD1  = 3'd2,
    WR   = 3'd3,
    RESP = 3'd4
  } state_e;

  function automatic logic is_aligned(input size_e size, input logic [1:0] offset);
    case (size)
      SZ_HALF: return ~offset[0];
      SZ_WORD: return offset == 2'b00;
      default: return 1'b1;
    endcase
  endfunction

  // Loads for which the requested bytes straddle two memory words.
  function automatic logic crosses_word(input size_e size, input logic [1:0] offset);
    case (size)
      SZ_HALF: return offset == 2'b11;
      SZ_WORD: return offset != 2'b00;
      default: return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/load_align.sv
// Selects the addressed bytes from one or two little-endian words and extends them.
module load_align
  import mem_access_pkg::*;
(
  input  logic [31:0] lo_word_i,
  input  logic [31:0] hi_word_i,
  input  logic [1:0]  offset_i,
  input  size_e       size_i,
  input  logic        sign_i,
  output logic [31:0] data_o
);

  logic [63:0] pair;
  logic [31:0] shifted;

  always_comb begin
    pair    = {hi_word_i, lo_word_i};
    shifted = pair[{offset_i, 3'b000} +: 32];
    case (size_i)
      SZ_BYTE: data_o = {{24{sign_i & shifted[7]}}, shifted[7:0]};
      SZ_HALF: data_o = {{16{sign_i & shifted[15]}}, shifted[15:0]};
      default: data_o = shifted;
    endcase
  end

endmodule

// File: rtl/mem_access_unit.sv
// Load/store unit: misaligned loads become one or two word reads, misaligned
// stores become a run of byte writes; illegal or rejected accesses answer with an error.
module mem_access_unit
  import mem_access_pkg::*;
#(
  parameter bit UNALIGNED_EN = 1'b1
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic        req_signed,
  input  logic [1:0]  req_size,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_err,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [1:0]  mem_size,
  output logic        mem_we,
  output logic        mem_re,
  input  logic [31:0] mem_rdata
);

  state_e      state_q, state_d;
  size_e       size_q, size_d;
  logic        we_q, we_d;
  logic        sign_q, sign_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [1:0]  cnt_q, cnt_d;
  logic [31:0] word0_q, word0_d;
  logic [31:0] rdata_q, rdata_d;
  logic        err_q, err_d;

  logic        aligned, crossing, reject;
  logic [1:0]  last_cnt;
  logic [31:0] word_addr, lo_word, load_data;

  assign aligned   = is_aligned(size_q, addr_q[1:0]);
  assign crossing  = crosses_word(size_q, addr_q[1:0]);
  assign last_cnt  = (size_q == SZ_WORD) ? 2'd3 : 2'd1;
  assign word_addr = {addr_q[31:2], 2'b00};
  assign lo_word   = (state_q == RD1) ? word0_q : mem_rdata;
  assign reject    = (size_e'(req_size) == SZ_UNAL) ||
                     (!UNALIGNED_EN && !is_aligned(size_e'(req_size), req_addr[1:0]));

  load_align u_load_align (
    .lo_word_i (lo_word),
    .hi_word_i (mem_rdata),
    .offset_i  (addr_q[1:0]),
    .size_i    (size_q),
    .sign_i    (sign_q),
    .data_o    (load_data)
  );

  // NOTE: sequential state uses non-blocking assignments so every register sees pre-edge values.
  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q <= IDLE;
      size_q  <= SZ_BYTE;
      we_q    <= 1'b0;
      sign_q  <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      cnt_q   <= '0;
      word0_q <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      size_q  <= size_d;
      we_q    <= we_d;
      sign_q  <= sign_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      cnt_q   <= cnt_d;
      word0_q <= word0_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end

  // NOTE: every _d starts at its _q, so no branch leaves a signal unassigned and no latch appears.
  always_comb begin
    state_d = state_q;
    size_d  = size_q;
    we_d    = we_q;
    sign_d  = sign_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    cnt_d   = cnt_q;
    word0_d = word0_q;
    rdata_d = rdata_q;
    err_d   = err_q;
    case (state_q)
      IDLE: begin
        if (req_valid) begin
          size_d  = size_e'(req_size);
          we_d    = req_we;
          sign_d  = req_signed;
          addr_d  = req_addr;
          wdata_d = req_wdata;
          cnt_d   = 2'd0;
          if (reject) begin
            state_d = RESP;
            rdata_d = '0;
            err_d   = 1'b1;
          end else begin
            state_d = req_we ? WR : RD0;
          end
        end
      end
      RD0: begin
        if (crossing) begin
          word0_d = mem_rdata;
          state_d = RD1;
        end else begin
          rdata_d = load_data;
          err_d   = 1'b0;
          state_d = RESP;
        end
      end
      RD1: begin
        rdata_d = load_data;
        err_d   = 1'b0;
        state_d = RESP;
      end
      WR: begin
        if (aligned || cnt_q == last_cnt) begin
          rdata_d = '0;
          err_d   = 1'b0;
          state_d = RESP;
        end else begin
          cnt_d = cnt_q + 2'd1;
        end
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Outputs are forced to zero while reset is low, even before the state register clears.
  always_comb begin
    req_ready  = 1'b0;
    resp_valid = 1'b0;
    resp_rdata = '0;
    resp_err   = 1'b0;
    mem_addr   = '0;
    mem_wdata  = '0;
    mem_size   = SZ_BYTE;
    mem_we     = 1'b0;
    mem_re     = 1'b0;
    if (reset) begin
      req_ready  = (state_q == IDLE);
      resp_valid = (state_q == RESP);
      resp_rdata = rdata_q;
      resp_err   = err_q;
      case (state_q)
        RD0: begin
          mem_addr = word_addr;
          mem_size = SZ_WORD;
          mem_re   = 1'b1;
        end
        RD1: begin
          mem_addr = word_addr + 32'd4;
          mem_size = SZ_WORD;
          mem_re   = 1'b1;
        end
        WR: begin
          mem_we = 1'b1;
          if (aligned) begin
            mem_addr  = addr_q;
            mem_size  = size_q;
            mem_wdata = wdata_q;
          end else begin
            mem_addr  = addr_q + {30'd0, cnt_q};
            mem_size  = SZ_BYTE;
            mem_wdata = {24'd0, wdata_q[{cnt_q, 3'b000} +: 8]};
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_access_unit.sv
// Scoreboard bench for mem_access_unit: a default instance plus one with misaligned access rejected.
module tb_mem_access_unit;

  typedef struct {
    string       name;
    logic [31:0] rdata;
    logic        err;
    int          t;
    int          lat;
  } resp_t;

  typedef struct {
    string       name;
    logic [31:0] addr;
    logic [31:0] data;
    logic [1:0]  size;
    int          t;
  } wr_t;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        req_valid = 1'b0, req_valid_s = 1'b0;
  logic        req_we = 1'b0, req_signed = 1'b0;
  logic [31:0] req_addr = '0, req_wdata = '0;
  logic [1:0]  req_size = '0;

  logic        req_ready, resp_valid, resp_err, mem_we, mem_re;
  logic [31:0] resp_rdata, mem_addr, mem_wdata, mem_rdata;
  logic [1:0]  mem_size;

  logic        req_ready_s, resp_valid_s, resp_err_s, mem_we_s, mem_re_s;
  logic [31:0] resp_rdata_s, mem_addr_s, mem_wdata_s;
  logic [31:0] mem_rdata_s = '0;
  logic [1:0]  mem_size_s;

  // Words 0..15 map 0x10000000..0x1000003C, 16 is 0xFFFFFFFC, 17 is 0x00000000.
  logic [31:0] mem_arr [0:17];
  int          rd_idx;

  resp_t exp_q[$];
  resp_t exp_s_q[$];
  wr_t   wr_q[$];
  resp_t mon_e, mon_s;
  wr_t   mon_w;
  logic [31:0] mask, wa;
  int          wk;

  int  cyc = 0;
  int  n_checks = 0;
  int  n_fail = 0;
  int  rd_cnt = 0;
  bit  strict_touch = 1'b0;

  mem_access_unit dut (
    .clock(clock), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we), .req_addr(req_addr),
    .req_wdata(req_wdata), .req_signed(req_signed), .req_size(req_size),
    .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_err(resp_err),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_size(mem_size),
    .mem_we(mem_we), .mem_re(mem_re), .mem_rdata(mem_rdata)
  );

  mem_access_unit #(.UNALIGNED_EN(1'b0)) dut_strict (
    .clock(clock), .reset(reset),
    .req_valid(req_valid_s), .req_ready(req_ready_s), .req_we(req_we), .req_addr(req_addr),
    .req_wdata(req_wdata), .req_signed(req_signed), .req_size(req_size),
    .resp_valid(resp_valid_s), .resp_rdata(resp_rdata_s), .resp_err(resp_err_s),
    .mem_addr(mem_addr_s), .mem_wdata(mem_wdata_s), .mem_size(mem_size_s),
    .mem_we(mem_we_s), .mem_re(mem_re_s), .mem_rdata(mem_rdata_s)
  );

  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  function automatic int widx(input logic [31:0] a);
    if (a[31:6] == 26'h0400000) return int'(a[5:2]);
    if (a[31:2] == 30'h3FFF_FFFF) return 16;
    if (a[31:2] == 30'h0) return 17;
    return -1;
  endfunction

  always_comb begin
    rd_idx    = widx(mem_addr);
    mem_rdata = (rd_idx >= 0) ? mem_arr[rd_idx] : 32'hDEAD_0000;
  end

  // Response and write monitors for the default instance.
  always @(negedge clock) begin
    if (resp_valid) begin
      n_checks++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL resp_unexpected: resp_valid=1 at cycle %0d, required no response", cyc);
      end else begin
        mon_e = exp_q.pop_front();
        if (resp_rdata !== mon_e.rdata || resp_err !== mon_e.err || cyc != mon_e.t + mon_e.lat) begin
          n_fail++;
          $display("FAIL %s: rdata=%h err=%b cycle=%0d, required rdata=%h err=%b cycle=%0d",
                   mon_e.name, resp_rdata, resp_err, cyc, mon_e.rdata, mon_e.err, mon_e.t + mon_e.lat);
        end
      end
    end
    if (mem_re) rd_cnt++;
    if (mem_we) begin
      n_checks++;
      if (wr_q.size() == 0) begin
        n_fail++;
        $display("FAIL write_unexpected: mem_we=1 addr=%h at cycle %0d, required no write", mem_addr, cyc);
      end else begin
        mon_w = wr_q.pop_front();
        mask  = (mon_w.size == 2'd0) ? 32'h0000_00FF : (mon_w.size == 2'd1) ? 32'h0000_FFFF : 32'hFFFF_FFFF;
        if (mem_addr !== mon_w.addr || mem_size !== mon_w.size ||
            (mem_wdata & mask) !== (mon_w.data & mask) || cyc != mon_w.t) begin
          n_fail++;
          $display("FAIL %s: addr=%h size=%0d wdata=%h cycle=%0d, required addr=%h size=%0d wdata=%h cycle=%0d",
                   mon_w.name, mem_addr, mem_size, mem_wdata, cyc, mon_w.addr, mon_w.size, mon_w.data, mon_w.t);
        end
      end
      for (int i = 0; i < ((mem_size == 2'd3) ? 4 : int'(mem_size) + 1); i++) begin
        wa = mem_addr + 32'(i);
        wk = widx(wa);
        if (wk >= 0) mem_arr[wk][{wa[1:0], 3'b000} +: 8] <= mem_wdata[8*i +: 8];
      end
    end
  end

  always @(negedge clock) begin
    if (mem_re_s || mem_we_s) strict_touch = 1'b1;
    if (resp_valid_s) begin
      n_checks++;
      if (exp_s_q.size() == 0) begin
        n_fail++;
        $display("FAIL strict_resp_unexpected: resp_valid=1 at cycle %0d, required no response", cyc);
      end else begin
        mon_s = exp_s_q.pop_front();
        if (resp_rdata_s !== mon_s.rdata || resp_err_s !== mon_s.err || cyc != mon_s.t + mon_s.lat) begin
          n_fail++;
          $display("FAIL %s: rdata=%h err=%b cycle=%0d, required rdata=%h err=%b cycle=%0d",
                   mon_s.name, resp_rdata_s, resp_err_s, cyc, mon_s.rdata, mon_s.err, mon_s.t + mon_s.lat);
        end
      end
    end
  end

  // Drives one request; t returns the cycle in which the handshake was seen.
  task automatic issue(input bit strict, input logic we, input logic [1:0] size, input logic sgn,
                       input logic [31:0] addr, input logic [31:0] wdata, output int t);
    bit got = 1'b0;
    t = -1;
    req_we = we; req_size = size; req_signed = sgn; req_addr = addr; req_wdata = wdata;
    if (strict) req_valid_s = 1'b1;
    else        req_valid   = 1'b1;
    for (int k = 0; k < 20 && !got; k++) begin
      @(negedge clock);
      if ((strict ? req_ready_s : req_ready) === 1'b1) begin
        got = 1'b1;
        t   = cyc;
      end
    end
    @(posedge clock); #1;
    req_valid = 1'b0; req_valid_s = 1'b0;
    n_checks++;
    if (!got) begin
      n_fail++;
      $display("FAIL accept_timeout: req_ready never seen for addr=%h, required within 20 cycles", addr);
    end
  endtask

  task automatic expect_resp(input bit strict, input string name, input logic [31:0] rdata,
                             input logic err, input int t, input int lat);
    resp_t r;
    r = '{name: name, rdata: rdata, err: err, t: t, lat: lat};
    if (strict) exp_s_q.push_back(r);
    else        exp_q.push_back(r);
  endtask

  task automatic expect_wr(input string name, input logic [31:0] addr, input logic [31:0] data,
                           input logic [1:0] size, input int t);
    wr_q.push_back('{name: name, addr: addr, data: data, size: size, t: t});
  endtask

  task automatic wait_done();
    int k = 0;
    while ((exp_q.size() != 0 || exp_s_q.size() != 0 || wr_q.size() != 0) && k < 30) begin
      @(negedge clock);
      k++;
    end
    n_checks++;
    if (exp_q.size() != 0 || exp_s_q.size() != 0 || wr_q.size() != 0) begin
      n_fail++;
      $display("FAIL drain_timeout: pending resp=%0d strict=%0d writes=%0d, required 0 0 0",
               exp_q.size(), exp_s_q.size(), wr_q.size());
      exp_q.delete(); exp_s_q.delete(); wr_q.delete();
    end
    @(posedge clock); #1;
  endtask

  task automatic test_reset();
    repeat (3) @(posedge clock);
    @(negedge clock);
    n_checks++;
    if ({req_ready, resp_valid, resp_err, mem_we, mem_re, mem_size} !== 7'b0) begin
      n_fail++;
      $display("FAIL reset_ctrl: ready/valid/err/we/re/size=%b, required 0000000",
               {req_ready, resp_valid, resp_err, mem_we, mem_re, mem_size});
    end
    n_checks++;
    if (resp_rdata !== 32'h0 || mem_addr !== 32'h0 || mem_wdata !== 32'h0) begin
      n_fail++;
      $display("FAIL reset_data: rdata=%h addr=%h wdata=%h, required all zero", resp_rdata, mem_addr, mem_wdata);
    end
    @(posedge clock); #1;
    reset = 1'b1;
    @(negedge clock);
    n_checks++;
    if (req_ready !== 1'b1 || req_ready_s !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_release_ready: ready=%b strict=%b, required 1 1", req_ready, req_ready_s);
    end
    @(posedge clock); #1;
  endtask

  task automatic test_load_byte();
    int t;
    mem_arr[0] <= 32'h8899_AABB;
    @(posedge clock); #1;
    issue(1'b0, 1'b0, 2'd0, 1'b1, 32'h1000_0002, 32'h0, t);
    expect_resp(1'b0, "ld_byte_signed", 32'hFFFF_FF99, 1'b0, t, 2);
    wait_done();
    issue(1'b0, 1'b0, 2'd0, 1'b0, 32'h1000_0002, 32'h0, t);
    expect_resp(1'b0, "ld_byte_unsigned", 32'h0000_0099, 1'b0, t, 2);
    wait_done();
    repeat (2) @(posedge clock);
    @(negedge clock);
    n_checks++;
    if (resp_rdata !== 32'h0000_0099 || resp_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL rdata_hold: rdata=%h valid=%b, required 00000099 0", resp_rdata, resp_valid);
    end
    @(posedge clock); #1;
  endtask

  task automatic test_load_cross();
    int t, r0;
    mem_arr[0] <= 32'h4433_2211;
    mem_arr[1] <= 32'h8877_6655;
    mem_arr[2] <= 32'h0000_00CC;
    @(posedge clock); #1;
    r0 = rd_cnt;
    issue(1'b0, 1'b0, 2'd3, 1'b0, 32'h1000_0003, 32'h0, t);
    expect_resp(1'b0, "ld_word_cross", 32'h7766_5544, 1'b0, t, 3);
    wait_done();
    n_checks++;
    if (rd_cnt - r0 != 2) begin
      n_fail++;
      $display("FAIL ld_word_cross_reads: %0d reads, required 2", rd_cnt - r0);
    end
    issue(1'b0, 1'b0, 2'd1, 1'b1, 32'h1000_0007, 32'h0, t);
    expect_resp(1'b0, "ld_half_cross_signed", 32'hFFFF_CC88, 1'b0, t, 3);
    wait_done();
    r0 = rd_cnt;
    issue(1'b0, 1'b0, 2'd1, 1'b0, 32'h1000_0005, 32'h0, t);
    expect_resp(1'b0, "ld_half_off1", 32'h0000_7766, 1'b0, t, 2);
    wait_done();
    n_checks++;
    if (rd_cnt - r0 != 1) begin
      n_fail++;
      $display("FAIL ld_half_off1_reads: %0d reads, required 1", rd_cnt - r0);
    end
  endtask

  task automatic test_store_aligned();
    int t;
    mem_arr[4] <= 32'h0;
    mem_arr[5] <= 32'h0;
    @(posedge clock); #1;
    issue(1'b0, 1'b1, 2'd3, 1'b0, 32'h1000_0010, 32'hCAFE_F00D, t);
    expect_wr("st_word_wr", 32'h1000_0010, 32'hCAFE_F00D, 2'd3, t + 1);
    expect_resp(1'b0, "st_word_resp", 32'h0, 1'b0, t, 2);
    wait_done();
    issue(1'b0, 1'b1, 2'd1, 1'b0, 32'h1000_0016, 32'h5555_1234, t);
    expect_wr("st_half_wr", 32'h1000_0016, 32'h0000_1234, 2'd1, t + 1);
    expect_resp(1'b0, "st_half_resp", 32'h0, 1'b0, t, 2);
    wait_done();
    issue(1'b0, 1'b1, 2'd0, 1'b0, 32'h1000_0013, 32'h0000_00A5, t);
    expect_wr("st_byte_wr", 32'h1000_0013, 32'h0000_00A5, 2'd0, t + 1);
    expect_resp(1'b0, "st_byte_resp", 32'h0, 1'b0, t, 2);
    wait_done();
    n_checks++;
    if (mem_arr[4] !== 32'hA5FE_F00D || mem_arr[5] !== 32'h1234_0000) begin
      n_fail++;
      $display("FAIL st_aligned_mem: words=%h %h, required A5FEF00D 12340000", mem_arr[4], mem_arr[5]);
    end
  endtask

  task automatic test_store_misaligned();
    int t;
    issue(1'b0, 1'b1, 2'd3, 1'b0, 32'h1000_0001, 32'hDEAD_BEEF, t);
    expect_wr("st_mis_b0", 32'h1000_0001, 32'h0000_00EF, 2'd0, t + 1);
    expect_wr("st_mis_b1", 32'h1000_0002, 32'h0000_00BE, 2'd0, t + 2);
    expect_wr("st_mis_b2", 32'h1000_0003, 32'h0000_00AD, 2'd0, t + 3);
    expect_wr("st_mis_b3", 32'h1000_0004, 32'h0000_00DE, 2'd0, t + 4);
    expect_resp(1'b0, "st_mis_resp", 32'h0, 1'b0, t, 5);
    wait_done();
    n_checks++;
    if (mem_arr[0] !== 32'hADBE_EF11 || mem_arr[1] !== 32'h8877_66DE) begin
      n_fail++;
      $display("FAIL st_mis_mem: words=%h %h, required ADBEEF11 887766DE", mem_arr[0], mem_arr[1]);
    end
  endtask

  task automatic test_wrap();
    int t;
    mem_arr[16] <= 32'hA1B2_C3D4;
    mem_arr[17] <= 32'h5566_E7F8;
    @(posedge clock); #1;
    issue(1'b0, 1'b0, 2'd3, 1'b0, 32'hFFFF_FFFE, 32'h0, t);
    expect_resp(1'b0, "ld_wrap", 32'hE7F8_A1B2, 1'b0, t, 3);
    wait_done();
    issue(1'b0, 1'b1, 2'd1, 1'b0, 32'hFFFF_FFFF, 32'h0000_BEEF, t);
    expect_wr("st_wrap_b0", 32'hFFFF_FFFF, 32'h0000_00EF, 2'd0, t + 1);
    expect_wr("st_wrap_b1", 32'h0000_0000, 32'h0000_00BE, 2'd0, t + 2);
    expect_resp(1'b0, "st_wrap_resp", 32'h0, 1'b0, t, 3);
    wait_done();
    n_checks++;
    if (mem_arr[16] !== 32'hEFB2_C3D4 || mem_arr[17] !== 32'h5566_E7BE) begin
      n_fail++;
      $display("FAIL st_wrap_mem: words=%h %h, required EFB2C3D4 5566E7BE", mem_arr[16], mem_arr[17]);
    end
  endtask

  task automatic test_errors();
    int t, r0;
    r0 = rd_cnt;
    issue(1'b0, 1'b0, 2'd2, 1'b0, 32'h1000_0000, 32'h0, t);
    expect_resp(1'b0, "size2_load", 32'h0, 1'b1, t, 1);
    wait_done();
    issue(1'b0, 1'b1, 2'd2, 1'b0, 32'h1000_0008, 32'h1234_5678, t);
    expect_resp(1'b0, "size2_store", 32'h0, 1'b1, t, 1);
    wait_done();
    n_checks++;
    if (rd_cnt != r0) begin
      n_fail++;
      $display("FAIL size2_no_read: %0d reads, required 0", rd_cnt - r0);
    end
    issue(1'b1, 1'b0, 2'd1, 1'b0, 32'h1000_0001, 32'h0, t);
    expect_resp(1'b1, "strict_mis_half", 32'h0, 1'b1, t, 1);
    wait_done();
    issue(1'b1, 1'b0, 2'd2, 1'b0, 32'h1000_0000, 32'h0, t);
    expect_resp(1'b1, "strict_size2", 32'h0, 1'b1, t, 1);
    wait_done();
    n_checks++;
    if (strict_touch !== 1'b0) begin
      n_fail++;
      $display("FAIL strict_no_access: mem_re/mem_we seen=%b, required 0", strict_touch);
    end
  endtask

  task automatic test_back_to_back();
    int t1, t2;
    mem_arr[12] <= 32'h0F1E_2D3C;
    mem_arr[13] <= 32'hC3D2_E1F0;
    @(posedge clock); #1;
    issue(1'b0, 1'b0, 2'd3, 1'b0, 32'h1000_0030, 32'h0, t1);
    expect_resp(1'b0, "b2b_first", 32'h0F1E_2D3C, 1'b0, t1, 2);
    issue(1'b0, 1'b0, 2'd3, 1'b0, 32'h1000_0034, 32'h0, t2);
    expect_resp(1'b0, "b2b_second", 32'hC3D2_E1F0, 1'b0, t2, 2);
    n_checks++;
    if (t2 != t1 + 3) begin
      n_fail++;
      $display("FAIL b2b_accept_gap: second accepted %0d cycles after first, required 3", t2 - t1);
    end
    wait_done();
  endtask

  task automatic test_reset_abort();
    int t;
    mem_arr[8] <= 32'h0;
    mem_arr[9] <= 32'h0;
    @(posedge clock); #1;
    issue(1'b0, 1'b1, 2'd3, 1'b0, 32'h1000_0021, 32'h1122_3344, t);
    expect_wr("abort_b0", 32'h1000_0021, 32'h0000_0044, 2'd0, t + 1);
    @(posedge clock); #1;
    reset = 1'b0;
    @(negedge clock);
    n_checks++;
    if (mem_we !== 1'b0 || req_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL abort_in_reset: mem_we=%b ready=%b, required 0 0", mem_we, req_ready);
    end
    @(posedge clock); #1;
    reset = 1'b1;
    @(negedge clock);
    n_checks++;
    if (req_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL abort_ready: ready=%b, required 1", req_ready);
    end
    repeat (6) @(posedge clock);
    #1;
    n_checks++;
    if (wr_q.size() != 0 || exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL abort_pending: writes=%0d resps=%0d, required 0 0", wr_q.size(), exp_q.size());
      wr_q.delete();
    end
    n_checks++;
    if (mem_arr[8] !== 32'h0000_4400 || mem_arr[9] !== 32'h0) begin
      n_fail++;
      $display("FAIL abort_mem: words=%h %h, required 00004400 00000000", mem_arr[8], mem_arr[9]);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin
    for (int i = 0; i < 18; i++) mem_arr[i] <= 32'h0;
    test_reset();
    test_load_byte();
    test_load_cross();
    test_store_aligned();
    test_store_misaligned();
    test_wrap();
    test_errors();
    test_back_to_back();
    test_reset_abort();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
